// File: rtl/nonogram_clue_encoder.sv
// Nonogram clue encoder: buffers one binary image (ROWS x COLS, 1 = black)
// and run-length encodes it into ROWS row clue words followed by COLS
// column clue words. Each line is scanned one pixel per cycle. The packed
// clue word is strobed on the cycle after the last pixel of the line.
module nonogram_clue_encoder #(
  parameter int ROWS     = 30,
  parameter int COLS     = 40,
  parameter int RUN_W    = 6,
  parameter int MAX_RUNS = 20,
  localparam int CLUE_W  = MAX_RUNS * RUN_W
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [COLS-1:0]   row_in,
  input  logic              row_valid_in,
  output logic [CLUE_W-1:0] clues_out,
  output logic              clue_valid_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int CNT_W  = $clog2(COLS + 1);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int RIDX_W = $clog2(MAX_RUNS);

  typedef enum logic [2:0] {IDLE, LOAD, ENC_ROWS, ENC_COLS, DONE} state_t;

  state_t              state_reg, state_next;
  logic [COLS-1:0]     buffer [0:ROWS-1];
  logic [ROW_W-1:0]    load_cnt_reg;
  logic [CNT_W-1:0]    pos_reg;       // pixel position within the line; == line_len is the strobe cycle
  logic [CNT_W-1:0]    line_reg;      // current row (row pass) or column (column pass)
  logic [RUN_W-1:0]    run_cnt_reg;   // length of the run currently open
  logic [RIDX_W-1:0]   run_idx_reg;   // slot the next closed run goes to
  logic [CLUE_W-1:0]   acc_reg;       // runs closed so far on this line
  logic [CLUE_W-1:0]   clues_reg;
  logic                valid_reg;

  logic                load_accept;
  logic                load_last;
  logic [CNT_W-1:0]    line_len;
  logic                last_line;
  logic                scan_phase;
  logic                final_bit;
  logic [ROW_W-1:0]    row_sel;
  logic [CNT_W-1:0]    bit_sel;
  logic                scan_bit;
  logic [RUN_W-1:0]    run_inc;
  logic                close_en;
  logic [RUN_W-1:0]    close_len;
  logic [CLUE_W-1:0]   word_closed;

  // A row is accepted in LOAD, or together with start_in while idle.
  assign load_accept = row_valid_in && ((state_reg == IDLE && start_in) || state_reg == LOAD);
  assign load_last   = row_valid_in && state_reg == LOAD && load_cnt_reg == ROW_W'(ROWS - 1);

  assign line_len   = (state_reg == ENC_ROWS) ? CNT_W'(COLS) : CNT_W'(ROWS);
  assign last_line  = (state_reg == ENC_ROWS) ? (line_reg == CNT_W'(ROWS - 1))
                                              : (line_reg == CNT_W'(COLS - 1));
  assign scan_phase = (pos_reg != line_len);
  assign final_bit  = (pos_reg == line_len - 1'b1);

  // Pixel selection: rows run left to right, columns run top to bottom.
  always_comb begin
    row_sel = '0;
    bit_sel = '0;
    if (state_reg == ENC_ROWS) begin
      row_sel = line_reg[ROW_W-1:0];
      bit_sel = CNT_W'(COLS - 1) - pos_reg;
    end else begin
      row_sel = pos_reg[ROW_W-1:0];
      bit_sel = CNT_W'(COLS - 1) - line_reg;
    end
  end

  assign scan_bit  = scan_phase && buffer[row_sel][bit_sel];
  assign run_inc   = (run_cnt_reg == RUN_W'(COLS)) ? run_cnt_reg : run_cnt_reg + 1'b1;
  // On a 0 this closes the open run; on the final pixel a 1 extends and closes it.
  assign close_en  = scan_bit || (run_cnt_reg != '0);
  assign close_len = scan_bit ? run_inc : run_cnt_reg;

  // Accumulated word with the currently closing run dropped into its slot.
  generate
    for (genvar gi = 0; gi < MAX_RUNS; gi++) begin : g_slot
      assign word_closed[gi*RUN_W +: RUN_W] =
        (close_en && run_idx_reg == RIDX_W'(gi)) ? close_len : acc_reg[gi*RUN_W +: RUN_W];
    end
  endgenerate

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start_in) state_next = LOAD;
      LOAD:     if (load_last) state_next = ENC_ROWS;
      ENC_ROWS: if (!scan_phase && last_line) state_next = ENC_COLS;
      ENC_COLS: if (!scan_phase && last_line) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Image buffer write port; contents survive the end of a frame.
  always_ff @(posedge clk_in) begin
    if (!reset_in && load_accept) begin
      buffer[load_cnt_reg] <= row_in;
    end
  end

  // State register, load counter and run-length datapath.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg    <= IDLE;
      load_cnt_reg <= '0;
      pos_reg      <= '0;
      line_reg     <= '0;
      run_cnt_reg  <= '0;
      run_idx_reg  <= '0;
      acc_reg      <= '0;
      clues_reg    <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE, LOAD: begin
          pos_reg     <= '0;
          line_reg    <= '0;
          run_cnt_reg <= '0;
          run_idx_reg <= '0;
          acc_reg     <= '0;
          if (load_last) begin
            load_cnt_reg <= '0;
          end else if (load_accept) begin
            load_cnt_reg <= load_cnt_reg + 1'b1;
          end
        end
        ENC_ROWS, ENC_COLS: begin
          if (scan_phase) begin
            pos_reg <= pos_reg + 1'b1;
            if (final_bit) begin
              clues_reg <= word_closed;
              valid_reg <= 1'b1;
            end else if (scan_bit) begin
              run_cnt_reg <= run_inc;
            end else if (run_cnt_reg != '0) begin
              acc_reg     <= word_closed;
              run_cnt_reg <= '0;
              if (run_idx_reg != RIDX_W'(MAX_RUNS - 1)) begin
                run_idx_reg <= run_idx_reg + 1'b1;
              end
            end
          end else begin
            // Strobe cycle: clear line state and move to the next line.
            pos_reg     <= '0;
            run_cnt_reg <= '0;
            run_idx_reg <= '0;
            acc_reg     <= '0;
            line_reg    <= last_line ? '0 : line_reg + 1'b1;
          end
        end
        default: begin
          pos_reg  <= '0;
          line_reg <= '0;
        end
      endcase
    end
  end

  assign clues_out      = clues_reg;
  assign clue_valid_out = valid_reg;
  assign busy_out       = (state_reg != IDLE);
  assign done_out       = (state_reg == DONE);

endmodule

// File: tb/tb_nonogram_clue_encoder.sv
// Bench for nonogram_clue_encoder: directed and random images, expected clue
// words from a plain run-length model of the image, plus strobe timing checks.
module tb_nonogram_clue_encoder;

  localparam int ROWS = 30;
  localparam int COLS = 40;
  localparam int CW   = 120;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic          start_in;
  logic [39:0]   row_in;
  logic          row_valid_in;
  logic [CW-1:0] clues_out;
  logic          clue_valid_out;
  logic          busy_out;
  logic          done_out;

  int checks   = 0;
  int failures = 0;
  logic [39:0] img [ROWS];
  bit frame_bad;

  always #5 clk_in = ~clk_in;

  nonogram_clue_encoder dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .start_in       (start_in),
    .row_in         (row_in),
    .row_valid_in   (row_valid_in),
    .clues_out      (clues_out),
    .clue_valid_out (clue_valid_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: collect the pixels of line k in scan order, list its runs, pack them.
  function automatic logic [CW-1:0] exp_word(input int k);
    int pix[$];
    int runs[$];
    int cnt;
    logic [CW-1:0] w;
    logic [39:0] rw;
    if (k < ROWS) begin
      rw = img[k];
      for (int c = 0; c < COLS; c++) pix.push_back(int'(rw[COLS-1-c]));
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        rw = img[r];
        pix.push_back(int'(rw[COLS-1-(k-ROWS)]));
      end
    end
    cnt = 0;
    foreach (pix[i]) begin
      if (pix[i] == 1) cnt++;
      else if (cnt > 0) begin runs.push_back(cnt); cnt = 0; end
    end
    if (cnt > 0) runs.push_back(cnt);
    w = '0;
    foreach (runs[i]) w[6*i +: 6] = 6'(runs[i]);
    return w;
  endfunction

  function automatic logic [39:0] rnd40();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[39:0];
  endfunction

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b1; start_in = 1'b0; row_valid_in = 1'b0; row_in = '0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  // One frame: load (optionally with row 0 on the start cycle and random gaps),
  // then check all 70 strobes, their spacing and the done pulse.
  // abort_at > 0 asserts reset right after that strobe number.
  task automatic run_frame(input string name, input bit merged, input int max_gap, input int abort_at);
    int first;
    int n;
    int g;
    int extra;
    bit seen;
    frame_bad = 1'b0;
    @(negedge clk_in);
    start_in = 1'b1; row_valid_in = merged; row_in = img[0];
    first = merged ? 1 : 0;
    for (int r = first; r < ROWS; r++) begin
      @(negedge clk_in);
      if (r == first) chk("busy_after_start", 120'(busy_out), 120'(1));
      start_in = 1'b0; row_valid_in = 1'b0;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        start_in = 1'($urandom_range(0, 1)); row_in = rnd40();
        @(negedge clk_in);
      end
      start_in = 1'($urandom_range(0, 1));
      row_valid_in = 1'b1; row_in = img[r];
    end
    for (int k = 0; k < ROWS + COLS; k++) begin
      n = 0; seen = 1'b0;
      while (!seen && n < 100) begin
        @(negedge clk_in);
        n++;
        row_valid_in = 1'($urandom_range(0, 1)); row_in = rnd40();
        start_in = (k < ROWS + COLS - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (clue_valid_out) seen = 1'b1;
      end
      chk($sformatf("%s_strobe%0d_seen", name, k), 120'(seen), 120'(1));
      if (!seen) begin frame_bad = 1'b1; return; end
      chk($sformatf("%s_strobe%0d_spacing", name, k), 120'(n), 120'((k < ROWS) ? COLS + 1 : ROWS + 1));
      chk($sformatf("%s_word%0d", name, k), clues_out, exp_word(k));
      if (abort_at == k + 1) begin
        reset_in = 1'b1; start_in = 1'b0; row_valid_in = 1'b0;
        @(negedge clk_in);
        chk("abort_clues", clues_out, '0);
        chk("abort_valid", 120'(clue_valid_out), 120'(0));
        chk("abort_busy", 120'(busy_out), 120'(0));
        chk("abort_done", 120'(done_out), 120'(0));
        reset_in = 1'b0;
        extra = 0;
        repeat (80) begin
          @(negedge clk_in);
          if (clue_valid_out || done_out) extra++;
        end
        chk("abort_quiet", 120'(extra), 120'(0));
        $display("frame %s aborted after strobe %0d checks=%0d", name, k + 1, checks);
        return;
      end
    end
    @(negedge clk_in);
    start_in = 1'b0; row_valid_in = 1'b0;
    chk($sformatf("%s_done_pulse", name), 120'(done_out), 120'(1));
    chk($sformatf("%s_valid_at_done", name), 120'(clue_valid_out), 120'(0));
    @(negedge clk_in);
    chk($sformatf("%s_done_low", name), 120'(done_out), 120'(0));
    chk($sformatf("%s_idle", name), 120'(busy_out), 120'(0));
    extra = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (clue_valid_out || done_out) extra++;
    end
    chk($sformatf("%s_quiet", name), 120'(extra), 120'(0));
    $display("frame %s complete checks=%0d failures=%0d", name, checks, failures);
  endtask

  initial begin
    reset_in = 1'b1; start_in = 1'b0; row_valid_in = 1'b0; row_in = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_clues", clues_out, '0);
    chk("reset_valid", 120'(clue_valid_out), 120'(0));
    chk("reset_busy", 120'(busy_out), 120'(0));
    chk("reset_done", 120'(done_out), 120'(0));
    reset_in = 1'b0;

    for (int r = 0; r < ROWS; r++) img[r] = '0;
    run_frame("zeros", 1'b0, 0, 0);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = {40{1'b1}};
    run_frame("ones", 1'b0, 0, 0);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = (r % 2 == 0) ? 40'hAAAAAAAAAA : 40'h5555555555;
    run_frame("checker", 1'b0, 1, 0);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[5] = 40'h0000000001;
    run_frame("pixel", 1'b0, 0, 0);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = rnd40();
    run_frame("random_dense", 1'b0, 3, 0);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = rnd40() & rnd40();
    run_frame("random_sparse", 1'b0, 2, 0);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = rnd40() | rnd40();
    run_frame("handshake", 1'b1, 4, 0);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = rnd40();
    run_frame("abort", 1'b0, 1, 35);
    if (frame_bad) do_reset();

    for (int r = 0; r < ROWS; r++) img[r] = rnd40();
    run_frame("after_abort", 1'b1, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
